// File: rtl/move_request_ctrl.sv
// move_request_ctrl: direction buttons -> one-cycle move pulses, one at a time.
// Ports: clock, reset (async high); key_left/right/up/down raw buttons;
//   enable gates new requests; move_done acks the last move;
//   move_left/right/up/down pulses; busy while a move is outstanding;
//   timeout_err sticky when move_done never arrives.
// Build option: define MOVE_REPEAT_EN for hold-to-repeat in HOLD.
module move_request_ctrl #(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int REPEAT_DELAY    = 6250000,
  parameter int REPEAT_RATE     = 1562500,
  parameter int DONE_TIMEOUT    = 64
) (
  input  logic clock,
  input  logic reset,
  input  logic key_left,
  input  logic key_right,
  input  logic key_up,
  input  logic key_down,
  input  logic enable,
  input  logic move_done,
  output logic move_left,
  output logic move_right,
  output logic move_up,
  output logic move_down,
  output logic busy,
  output logic timeout_err
);

  localparam int DBW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int TOW = $clog2(DONE_TIMEOUT + 1);
  localparam int STW = $clog2(DEBOUNCE_CYCLES + 4);
  localparam logic [DBW-1:0] DB_LAST = DBW'(DEBOUNCE_CYCLES - 1);
  localparam logic [TOW-1:0] TO_LAST = TOW'(DONE_TIMEOUT - 1);
  localparam logic [STW-1:0] ST_END  = STW'(DEBOUNCE_CYCLES + 3);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_HOLD
  } state_t;

  // bit order everywhere: 0=left 1=right 2=up 3=down
  logic [3:0] w_key;
  logic [3:0] r_sync1;
  logic [3:0] r_sync2;
  logic [3:0] r_deb;
  logic [3:0] r_deb_q;
  logic [3:0][DBW-1:0] r_db_cnt;

  assign w_key = {key_down, key_up, key_right, key_left};

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_sync1  <= '0;
      r_sync2  <= '0;
      r_deb    <= '0;
      r_deb_q  <= '0;
      r_db_cnt <= '0;
    end else begin
      r_sync1 <= w_key;
      r_sync2 <= r_sync1;
      r_deb_q <= r_deb;
      for (int k = 0; k < 4; k++) begin
        if (r_sync2[k] != r_deb[k]) begin
          if (r_db_cnt[k] == DB_LAST) begin
            r_deb[k]    <= ~r_deb[k];
            r_db_cnt[k] <= '0;
          end else begin
            r_db_cnt[k] <= r_db_cnt[k] + DBW'(1);
          end
        end else begin
          r_db_cnt[k] <= '0;
        end
      end
    end
  end

  // Edges are ignored until a key held through reset has had time
  // to debounce high, so it must be released and pressed again.
  logic [STW-1:0] r_st_cnt;
  logic           w_ready;

  assign w_ready = (r_st_cnt == ST_END);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_st_cnt <= '0;
    end else if (!w_ready) begin
      r_st_cnt <= r_st_cnt + STW'(1);
    end
  end

  logic       w_x_ok;
  logic       w_y_ok;
  logic [3:0] w_rise;
  logic [3:0] w_pick;

  assign w_x_ok = ~(r_deb[0] & r_deb[1]);
  assign w_y_ok = ~(r_deb[2] & r_deb[3]);
  assign w_rise = r_deb & ~r_deb_q &
                  {w_y_ok, w_y_ok, w_x_ok, w_x_ok};

  always_comb begin
    w_pick = 4'b0000;
    priority case (1'b1)
      w_rise[0]: w_pick = 4'b0001;
      w_rise[1]: w_pick = 4'b0010;
      w_rise[2]: w_pick = 4'b0100;
      w_rise[3]: w_pick = 4'b1000;
      default:   w_pick = 4'b0000;
    endcase
  end

  state_t         r_state;
  state_t         w_next;
  logic [3:0]     r_dir;
  logic [TOW-1:0] r_to_cnt;
  logic           r_err;
  logic           w_load;
  logic           w_err_set;

`ifdef MOVE_REPEAT_EN
  localparam int RP_MAX = (REPEAT_DELAY > REPEAT_RATE) ?
                          REPEAT_DELAY : REPEAT_RATE;
  localparam int RPW = $clog2(RP_MAX + 1);
  localparam logic [RPW-1:0] RP_SAT   = RPW'(RP_MAX);
  localparam logic [RPW-1:0] DLY_LAST = RPW'(REPEAT_DELAY - 1);
  localparam logic [RPW-1:0] RTE_LAST = RPW'(REPEAT_RATE - 1);

  logic [RPW-1:0] r_rep_cnt;
  logic           r_rep_first;
  logic [RPW-1:0] w_rep_lim;

  assign w_rep_lim = r_rep_first ? DLY_LAST : RTE_LAST;
`else
  logic w_unused_rep;
  assign w_unused_rep = ^{REPEAT_DELAY, REPEAT_RATE};
`endif

  always_comb begin
    w_next    = r_state;
    w_load    = 1'b0;
    w_err_set = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (enable && w_ready && |w_rise) begin
          w_next = S_ISSUE;
          w_load = 1'b1;
        end
      end
      S_ISSUE: w_next = S_WAIT;
      S_WAIT: begin
        if (move_done) begin
          w_next = S_HOLD;
        end else if (r_to_cnt == TO_LAST) begin
          w_next    = S_IDLE;
          w_err_set = 1'b1;
        end
      end
      S_HOLD: begin
        if (~|(r_deb & r_dir)) begin
          w_next = S_IDLE;
`ifdef MOVE_REPEAT_EN
        end else if (enable && r_rep_cnt >= w_rep_lim) begin
          w_next = S_ISSUE;
`endif
        end
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state  <= S_IDLE;
      r_dir    <= '0;
      r_to_cnt <= '0;
      r_err    <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_load) begin
        r_dir <= w_pick;
      end
      if (w_err_set) begin
        r_err <= 1'b1;
      end
      if (r_state == S_WAIT && r_to_cnt != TO_LAST) begin
        r_to_cnt <= r_to_cnt + TOW'(1);
      end else if (r_state != S_WAIT) begin
        r_to_cnt <= '0;
      end
    end
  end

`ifdef MOVE_REPEAT_EN
  // Counts from the pulse, so the period is measured pulse to pulse.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_rep_cnt   <= '0;
      r_rep_first <= 1'b0;
    end else begin
      unique case (r_state)
        S_ISSUE: r_rep_cnt <= RPW'(1);
        S_WAIT: begin
          if (r_rep_cnt != RP_SAT) begin
            r_rep_cnt <= r_rep_cnt + RPW'(1);
          end
        end
        S_HOLD: begin
          if (enable && r_rep_cnt != RP_SAT) begin
            r_rep_cnt <= r_rep_cnt + RPW'(1);
          end
        end
        default: r_rep_cnt <= '0;
      endcase
      if (w_load) begin
        r_rep_first <= 1'b1;
      end else if (r_state == S_HOLD && w_next == S_ISSUE) begin
        r_rep_first <= 1'b0;
      end
    end
  end
`endif

  logic w_issue;
  assign w_issue     = (r_state == S_ISSUE);
  assign move_left   = w_issue & r_dir[0];
  assign move_right  = w_issue & r_dir[1];
  assign move_up     = w_issue & r_dir[2];
  assign move_down   = w_issue & r_dir[3];
  assign busy        = w_issue | (r_state == S_WAIT);
  assign timeout_err = r_err;

endmodule

// File: tb/tb_move_request_ctrl.sv
// tb_move_request_ctrl: directed bench for move_request_ctrl.
// Small parameters; pulses are counted by a monitor and checked per test.
module tb_move_request_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic k_l = 1'b0, k_r = 1'b0, k_u = 1'b0, k_d = 1'b0;
  logic en = 1'b1;
  logic man_done = 1'b0;
  logic ack_auto = 1'b0;
  logic auto_en = 1'b0;
  logic done_w;
  logic mv_l, mv_r, mv_u, mv_d, busy, terr;

  assign done_w = man_done | ack_auto;

  move_request_ctrl #(
    .DEBOUNCE_CYCLES(4),
    .REPEAT_DELAY(20),
    .REPEAT_RATE(8),
    .DONE_TIMEOUT(16)
  ) dut (
    .clock(clk),
    .reset(rst),
    .key_left(k_l),
    .key_right(k_r),
    .key_up(k_u),
    .key_down(k_d),
    .enable(en),
    .move_done(done_w),
    .move_left(mv_l),
    .move_right(mv_r),
    .move_up(mv_u),
    .move_down(mv_d),
    .busy(busy),
    .timeout_err(terr)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int pc[4];
  int b[4];
  int last_pc = 0;
  int busy_cyc = 0;
  int multi = 0;
  logic [3:0] m;

  always @(negedge clk) begin
    m = {mv_d, mv_u, mv_r, mv_l};
    for (int k = 0; k < 4; k++)
      if (m[k]) pc[k] = pc[k] + 1;
    if (|m) last_pc = cyc;
    if ($countones(m) > 1) multi = multi + 1;
    if (busy) busy_cyc = busy_cyc + 1;
    ack_auto = auto_en && busy && !(|m);
  end

  int n_chk = 0;
  int n_fail = 0;

  task check(input string tag, input logic [31:0] got,
             input logic [31:0] exp);
    n_chk = n_chk + 1;
    if (got !== exp) begin
      n_fail = n_fail + 1;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task to_cyc(input int c);
    while (cyc < c) step(1);
  endtask

  task snap();
    for (int k = 0; k < 4; k++) b[k] = pc[k];
  endtask

  function automatic int d(input int k);
    return pc[k] - b[k];
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  int t, bb;

  initial begin
    for (int k = 0; k < 4; k++) pc[k] = 0;
    step(3);
    check("rst_busy", busy, 0);
    check("rst_moves", {mv_d, mv_u, mv_r, mv_l}, 0);
    check("rst_err", terr, 0);
    rst = 1'b0;
    step(15);

    // 1: single left, ack two cycles after pulse
    snap(); bb = busy_cyc;
    k_l = 1'b1; t = cyc;
    to_cyc(t + 9);
    man_done = 1'b1; step(1); man_done = 1'b0;
    step(2);
    check("t1_left", d(0), 1);
    check("t1_other", d(1) + d(2) + d(3), 0);
    check("t1_lat", last_pc - t, 7);
    check("t1_busy_cyc", busy_cyc - bb, 3);
    check("t1_hold_busy", busy, 0);
    k_l = 1'b0; step(12);

    // 2: bouncing up, then stable
    auto_en = 1'b1;
    snap();
    for (int i = 0; i < 10; i++) begin
      k_u = (i % 2 == 0);
      step(2);
    end
    check("t2_bounce", d(2), 0);
    k_u = 1'b1; t = cyc;
    step(12);
    check("t2_up", d(2), 1);
    check("t2_lat", last_pc - t, 7);
    k_u = 1'b0; step(12);

    // 3: conflicting presses
    snap();
    k_l = 1'b1; k_r = 1'b1; k_d = 1'b1; t = cyc;
    step(12);
    check("t3_down", d(3), 1);
    check("t3_lr", d(0) + d(1) + d(2), 0);
    check("t3_lat", last_pc - t, 7);
    k_l = 1'b0; k_r = 1'b0; k_d = 1'b0; step(12);
    snap();
    k_u = 1'b1; k_l = 1'b1;
    step(12);
    check("t3_ul_left", d(0), 1);
    check("t3_ul_up", d(2) + d(1) + d(3), 0);
    k_u = 1'b0; k_l = 1'b0; step(12);

    // 4: no ack -> timeout
    auto_en = 1'b0;
    snap(); bb = busy_cyc;
    k_r = 1'b1; t = cyc;
    to_cyc(t + 23);
    check("t4_busy_last", busy, 1);
    check("t4_err_pre", terr, 0);
    step(1);
    check("t4_busy_drop", busy, 0);
    check("t4_err", terr, 1);
    check("t4_right", d(1), 1);
    check("t4_busy_cyc", busy_cyc - bb, 17);
    k_r = 1'b0; step(12);
    auto_en = 1'b1;
    snap();
    k_u = 1'b1; step(12);
    check("t4_after_up", d(2), 1);
    check("t4_err_sticky", terr, 1);
    k_u = 1'b0; step(12);

    // enable gating: key raised while disabled is not a press
    snap();
    en = 1'b0; k_l = 1'b1; step(12);
    check("en_blocked", d(0) + d(1) + d(2) + d(3), 0);
    en = 1'b1; step(12);
    check("en_held", d(0), 0);
    k_l = 1'b0; step(12);
    k_l = 1'b1; step(12);
    check("en_repress", d(0), 1);
    k_l = 1'b0; step(12);

    // 5: hold down 60 cycles with immediate acks
    snap();
    k_d = 1'b1; t = cyc;
    to_cyc(t + 60);
    k_d = 1'b0;
    step(30);
`ifdef MOVE_REPEAT_EN
    check("t5_count", d(3), 6);
    check("t5_last", last_pc - t, 59);
`else
    check("t5_count", d(3), 1);
    check("t5_last", last_pc - t, 7);
`endif

    // 6: reset during WAIT_DONE
    auto_en = 1'b0;
    k_l = 1'b1; t = cyc;
    to_cyc(t + 9);
    check("t6_busy_pre", busy, 1);
    rst = 1'b1; #1;
    check("t6_rst_busy", busy, 0);
    check("t6_rst_moves", {mv_d, mv_u, mv_r, mv_l}, 0);
    check("t6_rst_err", terr, 0);
    step(2);
    rst = 1'b0;
    snap();
    step(25);
    check("t6_no_replay", d(0) + d(1) + d(2) + d(3), 0);
    k_l = 1'b0; step(12);
    auto_en = 1'b1;
    k_l = 1'b1; t = cyc;
    step(12);
    check("t6_repress", d(0), 1);
    check("t6_lat", last_pc - t, 7);
    k_l = 1'b0; step(12);

    check("onehot", multi, 0);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
